// File: rtl/overcurrent_guard.sv
// overcurrent_guard: synchronizes, filters and latches per-channel overcurrent trips with cooldown retry and lockout.
// Define BATTERY_LOCKOUT_EN to lock the battery channel out on its first trip.
module ocg_channel #(
  parameter int FILTER_LEN = 16,
  parameter int COOLDOWN   = 100000,
  parameter int MAX_RETRY  = 3,
  parameter bit LOCK_FIRST = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_raw,
  input  logic       i_clear,
  output logic       o_over,
  output logic       o_lock_nxt,
  output logic [1:0] o_trips
);
  typedef enum logic [1:0] {OK, TRIP, COOL, LOCK} state_t;
  localparam logic [7:0]  FL = 8'(FILTER_LEN);
  localparam logic [19:0] CD = 20'(COOLDOWN);
  localparam logic [1:0]  MR = 2'(MAX_RETRY);
  state_t      r_state, w_state_nxt;
  logic [1:0]  r_sync;
  logic [7:0]  r_filt, w_filt_nxt;
  logic [19:0] r_cool, w_cool_nxt;
  logic [1:0]  r_trips, w_trips_nxt;
  logic        r_over;
  logic        w_raw;
  assign w_raw = r_sync[1];
  always_comb begin
    w_state_nxt = r_state;
    w_filt_nxt  = '0;
    w_cool_nxt  = r_cool;
    w_trips_nxt = (i_clear && r_state != LOCK) ? 2'd0 : r_trips;
    case (r_state)
      OK: begin
        w_filt_nxt = w_raw ? ((r_filt == FL) ? r_filt : r_filt + 8'd1) : 8'd0;
        if (w_raw && r_filt == FL - 8'd1) begin
          if (LOCK_FIRST || w_trips_nxt >= MR) begin
            w_state_nxt = LOCK;
            w_trips_nxt = (LOCK_FIRST && w_trips_nxt != 2'd3) ? w_trips_nxt + 2'd1 : w_trips_nxt;
          end else begin
            w_state_nxt = TRIP;
            w_trips_nxt = w_trips_nxt + 2'd1;
          end
        end
      end
      TRIP: begin
        w_state_nxt = w_raw ? TRIP : COOL;
        w_cool_nxt  = w_raw ? r_cool : CD - 20'd1;
      end
      COOL: begin
        // Reload one above the TRIP->COOL value so release after the last fall matches the TRIP path.
        w_cool_nxt  = w_raw ? CD : (r_cool == 20'd0 ? r_cool : r_cool - 20'd1);
        w_state_nxt = (!w_raw && r_cool == 20'd0) ? OK : COOL;
      end
      LOCK: begin
        w_state_nxt = (i_clear && !w_raw) ? OK : LOCK;
        w_trips_nxt = (i_clear && !w_raw) ? 2'd0 : r_trips;
      end
      default: w_state_nxt = OK;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= OK;
      r_sync  <= '0;
      r_filt  <= '0;
      r_cool  <= '0;
      r_trips <= '0;
      r_over  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sync  <= {r_sync[0], i_raw};
      r_filt  <= w_filt_nxt;
      r_cool  <= w_cool_nxt;
      r_trips <= w_trips_nxt;
      r_over  <= (w_state_nxt != OK);
    end
  end
  assign o_over     = r_over;
  assign o_lock_nxt = (w_state_nxt == LOCK);
  assign o_trips    = r_trips;
endmodule

module overcurrent_guard #(
  parameter int FILTER_LEN = 16,
  parameter int COOLDOWN   = 100000,
  parameter int MAX_RETRY  = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RawA,
  input  logic       RawB,
  input  logic       RawBat,
  input  logic       ClearFault,
  output logic       OverA,
  output logic       OverB,
  output logic       OverBat,
  output logic       Lockout,
  output logic [1:0] TripsA,
  output logic [1:0] TripsB,
  output logic [1:0] TripsBat
);
`ifdef BATTERY_LOCKOUT_EN
  localparam bit BAT_LOCK_FIRST = 1'b1;
`else
  localparam bit BAT_LOCK_FIRST = 1'b0;
`endif
  logic [2:0] w_lock_nxt;
  logic       r_lockout;
  ocg_channel #(.FILTER_LEN(FILTER_LEN), .COOLDOWN(COOLDOWN), .MAX_RETRY(MAX_RETRY), .LOCK_FIRST(1'b0)) u_a (
    .CLK(CLK), .RST(RST), .i_raw(RawA), .i_clear(ClearFault),
    .o_over(OverA), .o_lock_nxt(w_lock_nxt[0]), .o_trips(TripsA));
  ocg_channel #(.FILTER_LEN(FILTER_LEN), .COOLDOWN(COOLDOWN), .MAX_RETRY(MAX_RETRY), .LOCK_FIRST(1'b0)) u_b (
    .CLK(CLK), .RST(RST), .i_raw(RawB), .i_clear(ClearFault),
    .o_over(OverB), .o_lock_nxt(w_lock_nxt[1]), .o_trips(TripsB));
  ocg_channel #(.FILTER_LEN(FILTER_LEN), .COOLDOWN(COOLDOWN), .MAX_RETRY(MAX_RETRY), .LOCK_FIRST(BAT_LOCK_FIRST)) u_bat (
    .CLK(CLK), .RST(RST), .i_raw(RawBat), .i_clear(ClearFault),
    .o_over(OverBat), .o_lock_nxt(w_lock_nxt[2]), .o_trips(TripsBat));
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_lockout <= 1'b0;
    else     r_lockout <= |w_lock_nxt;
  end
  assign Lockout = r_lockout;
endmodule

// File: tb/tb_overcurrent_guard.sv
// tb_overcurrent_guard: directed checks of filtering, trip/release timing, retry lockout, clear and async reset.
module tb_overcurrent_guard;
`ifdef BATTERY_LOCKOUT_EN
  localparam bit BAT_LOCK = 1'b1;
`else
  localparam bit BAT_LOCK = 1'b0;
`endif
  logic CLK = 1'b0, RST = 1'b1;
  logic RawA = 1'b0, RawB = 1'b0, RawBat = 1'b0, ClearFault = 1'b0;
  logic OverA, OverB, OverBat, Lockout;
  logic [1:0] TripsA, TripsB, TripsBat;
  int checks = 0, errors = 0;

  overcurrent_guard #(.FILTER_LEN(4), .COOLDOWN(10), .MAX_RETRY(2)) dut (
    .CLK(CLK), .RST(RST), .RawA(RawA), .RawB(RawB), .RawBat(RawBat), .ClearFault(ClearFault),
    .OverA(OverA), .OverB(OverB), .OverBat(OverBat), .Lockout(Lockout),
    .TripsA(TripsA), .TripsB(TripsB), .TripsBat(TripsBat));

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    tick(2);
    checks++;
    if ({OverA, OverB, OverBat, Lockout, TripsA, TripsB, TripsBat} !== 10'd0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=0", {OverA, OverB, OverBat, Lockout, TripsA, TripsB, TripsBat});
    end
    RST = 1'b0;
    tick(3);
    checks++;
    if ({OverA, OverB, OverBat, Lockout, TripsA, TripsB, TripsBat} !== 10'd0) begin
      errors++; $display("FAIL post_reset_outputs got=%b exp=0", {OverA, OverB, OverBat, Lockout, TripsA, TripsB, TripsBat});
    end
  endtask

  task automatic test_glitch;
    logic seen = 1'b0;
    RawA = 1'b1;
    tick(3);
    RawA = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      seen |= OverA;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL glitch_overA got=%b exp=0", seen); end
    checks++;
    if (TripsA !== 2'd0) begin errors++; $display("FAIL glitch_tripsA got=%0d exp=0", TripsA); end
  endtask

  task automatic test_trip_release;
    RawA = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      checks++;
      if (OverA !== (k >= 6)) begin errors++; $display("FAIL trip_overA edge=%0d got=%b exp=%b", k, OverA, k >= 6); end
    end
    RawA = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      checks++;
      if (OverA !== (k < 13)) begin errors++; $display("FAIL release_overA edge=%0d got=%b exp=%b", k, OverA, k < 13); end
    end
    checks++;
    if (TripsA !== 2'd1) begin errors++; $display("FAIL trip_tripsA got=%0d exp=1", TripsA); end
  endtask

  task automatic test_cool_restart;
    RawA = 1'b1;
    tick(8);
    checks++;
    if (OverA !== 1'b1 || TripsA !== 2'd2) begin
      errors++; $display("FAIL restart_trip over=%b trips=%0d exp over=1 trips=2", OverA, TripsA);
    end
    RawA = 1'b0;
    tick(6);
    RawA = 1'b1;
    tick(2);
    RawA = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      checks++;
      if (OverA !== (k < 13)) begin errors++; $display("FAIL restart_overA edge=%0d got=%b exp=%b", k, OverA, k < 13); end
    end
  endtask

  task automatic test_lockout;
    for (int t = 0; t < 2; t++) begin
      RawB = 1'b1;
      tick(8);
      RawB = 1'b0;
      tick(15);
      checks++;
      if (OverB !== 1'b0 || Lockout !== 1'b0 || TripsB !== 2'(t + 1)) begin
        errors++; $display("FAIL retry%0d over=%b lock=%b trips=%0d exp 0 0 %0d", t, OverB, Lockout, TripsB, t + 1);
      end
    end
    RawB = 1'b1;
    tick(5);
    checks++;
    if (OverB !== 1'b0 || Lockout !== 1'b0) begin errors++; $display("FAIL lock_edge5 over=%b lock=%b exp 0 0", OverB, Lockout); end
    tick(1);
    checks++;
    if (OverB !== 1'b1 || Lockout !== 1'b1) begin errors++; $display("FAIL lock_edge6 over=%b lock=%b exp 1 1", OverB, Lockout); end
    tick(2);
    RawB = 1'b0;
    tick(30);
    checks++;
    if (OverB !== 1'b1 || Lockout !== 1'b1 || TripsB !== 2'd2) begin
      errors++; $display("FAIL lock_hold over=%b lock=%b trips=%0d exp 1 1 2", OverB, Lockout, TripsB);
    end
    RawB = 1'b1;
    tick(3);
    ClearFault = 1'b1;
    tick(1);
    ClearFault = 1'b0;
    checks++;
    if (OverB !== 1'b1 || Lockout !== 1'b1 || TripsB !== 2'd2) begin
      errors++; $display("FAIL clear_raw_high over=%b lock=%b trips=%0d exp 1 1 2", OverB, Lockout, TripsB);
    end
    checks++;
    if (TripsA !== 2'd0) begin errors++; $display("FAIL clear_tripsA got=%0d exp=0", TripsA); end
    tick(2);
    RawB = 1'b0;
    tick(3);
    ClearFault = 1'b1;
    tick(1);
    ClearFault = 1'b0;
    checks++;
    if (OverB !== 1'b0 || Lockout !== 1'b0 || TripsB !== 2'd0) begin
      errors++; $display("FAIL clear_raw_low over=%b lock=%b trips=%0d exp 0 0 0", OverB, Lockout, TripsB);
    end
  endtask

  task automatic test_async_reset;
    RawBat = 1'b1;
    tick(8);
    checks++;
    if (OverBat !== 1'b1 || TripsBat !== 2'd1) begin
      errors++; $display("FAIL rst_pre over=%b trips=%0d exp 1 1", OverBat, TripsBat);
    end
    RawBat = 1'b0;
    tick(6);
    #2 RST = 1'b1;
    #1;
    checks++;
    if (OverBat !== 1'b0 || TripsBat !== 2'd0 || Lockout !== 1'b0) begin
      errors++; $display("FAIL rst_async over=%b trips=%0d lock=%b exp 0 0 0", OverBat, TripsBat, Lockout);
    end
    #1 RST = 1'b0;
    tick(2);
    checks++;
    if (OverBat !== 1'b0) begin errors++; $display("FAIL rst_recover over=%b exp 0", OverBat); end
  endtask

  task automatic test_battery;
    RawBat = 1'b1;
    tick(6);
    checks++;
    if (OverBat !== 1'b1 || TripsBat !== 2'd1 || Lockout !== BAT_LOCK) begin
      errors++; $display("FAIL bat_trip over=%b trips=%0d lock=%b exp 1 1 %b", OverBat, TripsBat, Lockout, BAT_LOCK);
    end
    RawBat = 1'b0;
    tick(15);
    checks++;
    if (OverBat !== BAT_LOCK || Lockout !== BAT_LOCK || TripsBat !== 2'd1) begin
      errors++; $display("FAIL bat_after over=%b lock=%b trips=%0d exp %b %b 1", OverBat, Lockout, TripsBat, BAT_LOCK, BAT_LOCK);
    end
    ClearFault = 1'b1;
    tick(1);
    ClearFault = 1'b0;
    checks++;
    if (OverBat !== 1'b0 || Lockout !== 1'b0 || TripsBat !== 2'd0) begin
      errors++; $display("FAIL bat_clear over=%b lock=%b trips=%0d exp 0 0 0", OverBat, Lockout, TripsBat);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_trip_release();
    test_cool_restart();
    test_lockout();
    test_async_reset();
    test_battery();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
